// File: rtl/audio_byte_unpacker_if.sv
// audio_byte_unpacker_if: FIFO-side and audio-side signals of the byte unpacker
interface audio_byte_unpacker_if #(parameter int LEVEL_W = 8);
  logic [7:0] fifo_data_i;
  logic [LEVEL_W-1:0] fifo_level_i;
  logic fifo_rd_o;
  logic sample_tick_i;
  logic signed [23:0] left_o;
  logic signed [23:0] right_o;
  logic sample_valid_o;
  logic more_req_o;
  logic underrun_o;
  logic [15:0] underrun_cnt_o;
  modport master(
    output fifo_data_i, fifo_level_i, sample_tick_i,
    input fifo_rd_o, left_o, right_o, sample_valid_o, more_req_o, underrun_o, underrun_cnt_o
  );
  modport slave(
    input fifo_data_i, fifo_level_i, sample_tick_i,
    output fifo_rd_o, left_o, right_o, sample_valid_o, more_req_o, underrun_o, underrun_cnt_o
  );
endinterface

// File: rtl/audio_byte_unpacker.sv
// audio_byte_unpacker: assembles little-endian FIFO bytes into 24-bit MSB-aligned frames.
// UNPACK_UNDERRUN_MUTE_EN: zero outputs on underrun instead of repeating the last sample.
module audio_byte_unpacker #(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int CHANNELS = 2,
  parameter int LEVEL_W = 8,
  parameter int START_LEVEL = 16,
  parameter int LOW_WATER = 64
) (
  input logic clk_i,
  input logic rst_n_i,
  audio_byte_unpacker_if.slave bus
);
  localparam int NB = BYTES_PER_SAMPLE * CHANNELS;
  typedef enum logic [1:0] {PREBUF, FETCH, SETTLE, READY} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q;
  logic [7:0] byte_q [8];
  logic [23:0] left_d, right_d;
  logic has_data;
  assign has_data = |bus.fifo_level_i;
  always_comb begin
    state_d = state_q;
    bus.fifo_rd_o = rst_n_i && state_q == FETCH && has_data;
    case (state_q)
      PREBUF: state_d = bus.fifo_level_i >= LEVEL_W'(START_LEVEL) ? FETCH : PREBUF;
      FETCH: state_d = has_data ? SETTLE : FETCH;
      SETTLE: state_d = idx_q == 3'(NB) ? READY : FETCH;
      default: state_d = bus.sample_tick_i ? FETCH : READY;
    endcase
  end
  // Byte k of a channel lands k bytes above the zero-filled LSBs; mono reuses the left bytes
  always_comb begin
    left_d = '0;
    right_d = '0;
    for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
      left_d[8*(3-BYTES_PER_SAMPLE+k) +: 8] = byte_q[k];
      right_d[8*(3-BYTES_PER_SAMPLE+k) +: 8] = byte_q[k+BYTES_PER_SAMPLE*(CHANNELS-1)];
    end
  end
  always_ff @(posedge clk_i)
    if (bus.fifo_rd_o) byte_q[idx_q] <= bus.fifo_data_i;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= PREBUF;
      idx_q <= '0;
      bus.left_o <= '0;
      bus.right_o <= '0;
      bus.sample_valid_o <= 1'b0;
      bus.underrun_o <= 1'b0;
      bus.underrun_cnt_o <= '0;
      bus.more_req_o <= 1'b1;
    end else begin
      state_q <= state_d;
      bus.sample_valid_o <= bus.sample_tick_i;
      bus.more_req_o <= bus.fifo_level_i < LEVEL_W'(LOW_WATER);
      if (bus.fifo_rd_o) idx_q <= idx_q + 3'd1;
      if (bus.sample_tick_i) begin
        if (state_q == READY) begin
          bus.left_o <= left_d;
          bus.right_o <= right_d;
          idx_q <= '0;
        end else if (state_q == PREBUF) begin
          bus.left_o <= '0;
          bus.right_o <= '0;
        end else begin
          bus.underrun_o <= 1'b1;
          bus.underrun_cnt_o <= bus.underrun_cnt_o + 16'(bus.underrun_cnt_o != 16'hFFFF);
`ifdef UNPACK_UNDERRUN_MUTE_EN
          bus.left_o <= '0;
          bus.right_o <= '0;
`else
          bus.left_o <= bus.left_o;
          bus.right_o <= bus.right_o;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_byte_unpacker.sv
// tb_audio_byte_unpacker: scoreboard bench for the default stereo build and a 3-byte mono build
module tb_audio_byte_unpacker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  audio_byte_unpacker_if #(.LEVEL_W(8)) b();
  audio_byte_unpacker_if #(.LEVEL_W(8)) m();
  audio_byte_unpacker dut (.clk_i(clk), .rst_n_i(rst_n), .bus(b));
  audio_byte_unpacker #(.BYTES_PER_SAMPLE(3), .CHANNELS(1)) dut_mono (.clk_i(clk), .rst_n_i(rst_n), .bus(m));
  logic [7:0] fq[$];
  logic [7:0] fm[$];
  logic [47:0] ea[$];
  logic [47:0] em[$];
  int lvl_force = -1;
  int checks = 0;
  int errors = 0;
  int pops_a = 0;
  logic prev_pa = 1'b0;
  logic [47:0] last_a;
  logic [47:0] under_a;

  function automatic logic [47:0] st_frame(input logic [7:0] b0, b1, b2, b3);
    return {b1, b0, 8'h00, b3, b2, 8'h00};
  endfunction

  task automatic cyc(input logic ta, input logic tm);
    logic pa, pm;
    logic [7:0] d;
    logic [47:0] e;
    b.sample_tick_i = ta;
    m.sample_tick_i = tm;
    b.fifo_data_i = fq.size() != 0 ? fq[0] : 8'h00;
    b.fifo_level_i = lvl_force >= 0 ? 8'(lvl_force) : 8'(fq.size());
    m.fifo_data_i = fm.size() != 0 ? fm[0] : 8'h00;
    m.fifo_level_i = 8'(fm.size());
    #1;
    pa = b.fifo_rd_o;
    pm = m.fifo_rd_o;
    if (pa) begin
      checks++;
      if (prev_pa) begin errors++; $display("FAIL rd_spacing: fifo_rd_o=1 on consecutive cycles, required gap"); end
    end
    if (!rst_n) begin
      checks++;
      if (pa !== 1'b0 || pm !== 1'b0) begin errors++; $display("FAIL reset_pop: rd=%b/%b required 0/0", pa, pm); end
    end
    prev_pa = pa;
    @(posedge clk);
    #1;
    if (pa) begin pops_a++; if (fq.size() != 0) d = fq.pop_front(); end
    if (pm && fm.size() != 0) d = fm.pop_front();
    if (b.sample_valid_o === 1'b1) begin
      checks++;
      if (ea.size() == 0) begin errors++; $display("FAIL stereo_unexpected_valid: got %h none expected", {b.left_o, b.right_o}); end
      else begin
        e = ea.pop_front();
        if ({b.left_o, b.right_o} !== e) begin errors++; $display("FAIL stereo_frame: got %h required %h", {b.left_o, b.right_o}, e); end
      end
    end
    if (m.sample_valid_o === 1'b1) begin
      checks++;
      if (em.size() == 0) begin errors++; $display("FAIL mono_unexpected_valid: got %h none expected", {m.left_o, m.right_o}); end
      else begin
        e = em.pop_front();
        if ({m.left_o, m.right_o} !== e) begin errors++; $display("FAIL mono_frame: got %h required %h", {m.left_o, m.right_o}, e); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    checks += 7;
    if (b.left_o !== 24'h0) begin errors++; $display("FAIL rst_left: got %h required 0", b.left_o); end
    if (b.right_o !== 24'h0) begin errors++; $display("FAIL rst_right: got %h required 0", b.right_o); end
    if (b.sample_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", b.sample_valid_o); end
    if (b.fifo_rd_o !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b required 0", b.fifo_rd_o); end
    if (b.underrun_o !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", b.underrun_o); end
    if (b.underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h required 0", b.underrun_cnt_o); end
    if (b.more_req_o !== 1'b1) begin errors++; $display("FAIL rst_more_req: got %b required 1", b.more_req_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_mono();
    fm = '{8'h01, 8'h02, 8'h83, 8'h04, 8'h05, 8'h86};
    repeat (10) fm.push_back(8'h00);
    em.push_back({24'h830201, 24'h830201});
    em.push_back({24'h860504, 24'h860504});
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, i == 9 || i == 19);
      if (i == 10) begin
        checks++;
        if (m.sample_valid_o !== 1'b0) begin errors++; $display("FAIL mono_valid_width: got %b required 0", m.sample_valid_o); end
      end
    end
    checks++;
    if (em.size() != 0) begin errors++; $display("FAIL mono_missing: %0d frames left, required 0", em.size()); end
  endtask

  task automatic test_frames();
    logic [7:0] by [16];
    by = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 16; i++) fq.push_back(by[i]);
    for (int f = 0; f < 4; f++) ea.push_back(st_frame(by[4*f], by[4*f+1], by[4*f+2], by[4*f+3]));
    // first tick lands exactly when READY is reached
    for (int i = 0; i < 310; i++) cyc(i == 9 || i == 109 || i == 209 || i == 309, 1'b0);
    checks += 2;
    if (ea.size() != 0) begin errors++; $display("FAIL stereo_missing: %0d frames left, required 0", ea.size()); end
    if (b.underrun_o !== 1'b0) begin errors++; $display("FAIL latency_underrun: got %b required 0", b.underrun_o); end
    last_a = st_frame(by[12], by[13], by[14], by[15]);
  endtask

  task automatic test_underrun();
`ifdef UNPACK_UNDERRUN_MUTE_EN
    under_a = 48'h0;
`else
    under_a = last_a;
`endif
    for (int n = 1; n <= 2; n++) begin
      ea.push_back(under_a);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      checks += 2;
      if (b.underrun_o !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b required 1", b.underrun_o); end
      if (b.underrun_cnt_o !== 16'(n)) begin errors++; $display("FAIL underrun_cnt: got %0d required %0d", b.underrun_cnt_o, n); end
    end
    b.sample_tick_i = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    b.sample_tick_i = 1'b0;
    checks += 3;
    if (b.underrun_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL underrun_sat: got %h required ffff", b.underrun_cnt_o); end
    if ({b.left_o, b.right_o} !== under_a) begin errors++; $display("FAIL underrun_out: got %h required %h", {b.left_o, b.right_o}, under_a); end
    if (b.underrun_o !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b required 1", b.underrun_o); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_more_req();
    lvl_force = 10;
    cyc(1'b0, 1'b0);
    lvl_force = 70;
    cyc(1'b0, 1'b0);
    checks++;
    if (b.more_req_o !== 1'b0) begin errors++; $display("FAIL more_req_70: got %b required 0", b.more_req_o); end
    lvl_force = 63;
    b.fifo_level_i = 8'd63;
    #1;
    checks++;
    if (b.more_req_o !== 1'b0) begin errors++; $display("FAIL more_req_lat63: got %b required 0", b.more_req_o); end
    cyc(1'b0, 1'b0);
    checks++;
    if (b.more_req_o !== 1'b1) begin errors++; $display("FAIL more_req_63: got %b required 1", b.more_req_o); end
    lvl_force = 64;
    b.fifo_level_i = 8'd64;
    #1;
    checks++;
    if (b.more_req_o !== 1'b1) begin errors++; $display("FAIL more_req_lat64: got %b required 1", b.more_req_o); end
    cyc(1'b0, 1'b0);
    checks += 2;
    if (b.more_req_o !== 1'b0) begin errors++; $display("FAIL more_req_64: got %b required 0", b.more_req_o); end
    if (b.underrun_o !== 1'b1) begin errors++; $display("FAIL underrun_hold: got %b required 1", b.underrun_o); end
    lvl_force = -1;
  endtask

  task automatic test_midreset();
    int p0;
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    checks += 2;
    if (b.underrun_o !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b required 0", b.underrun_o); end
    if (b.underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL cnt_clear: got %0d required 0", b.underrun_cnt_o); end
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 1; i <= 12; i++) fq.push_back(8'hB0 + 8'(i));
    pops_a = 0;
    for (int i = 0; i < 40 && pops_a < 3; i++) cyc(1'b0, 1'b0);
    checks++;
    if (pops_a != 3) begin errors++; $display("FAIL midreset_pops: got %0d required 3", pops_a); end
    cyc(1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (fq.size() != 13) begin errors++; $display("FAIL midreset_fifo: got %0d bytes required 13", fq.size()); end
    p0 = pops_a;
    ea.push_back(48'h0);
    for (int i = 0; i < 20; i++) cyc(i == 5, 1'b0);
    checks += 2;
    if (pops_a != p0) begin errors++; $display("FAIL prebuf_pops: got %0d required %0d", pops_a, p0); end
    if (b.underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL prebuf_tick_cnt: got %0d required 0", b.underrun_cnt_o); end
    fq.push_back(8'hC1);
    fq.push_back(8'hC2);
    fq.push_back(8'hC3);
    ea.push_back(st_frame(8'hA4, 8'hB1, 8'hB2, 8'hB3));
    for (int i = 0; i < 12; i++) cyc(i == 10, 1'b0);
    checks++;
    if (ea.size() != 0) begin errors++; $display("FAIL midreset_missing: %0d frames left, required 0", ea.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    b.sample_tick_i = 1'b0;
    b.fifo_data_i = 8'h00;
    b.fifo_level_i = 8'h00;
    m.sample_tick_i = 1'b0;
    m.fifo_data_i = 8'h00;
    m.fifo_level_i = 8'h00;
    test_reset();
    test_mono();
    test_frames();
    test_underrun();
    test_more_req();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_byte_unpacker.md
AUDIO_BYTE_UNPACKER -- requirements
Module: audio_byte_unpacker

Interface
REQ-001 Parameters SHALL be:
- BYTES_PER_SAMPLE, default 2: bytes per channel sample, legal range 1..3.
- CHANNELS, default 2: 1 = mono, 2 = stereo.
- LEVEL_W, default 8: width of the FIFO fill-level input.
- START_LEVEL, default 16: fill level required to leave prebuffer.
- LOW_WATER, default 64: refill-request threshold.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock.
- rst_n_i  in  1  synchronous active-low reset.
- fifo_data_i  in  8  show-ahead FIFO head byte.
- fifo_level_i  in  LEVEL_W  FIFO fill count.
- fifo_rd_o  out  1  pops one byte.
- sample_tick_i  in  1  one-cycle pulse, one per output frame.
- left_o  out  24  signed left sample.
- right_o  out  24  signed right sample.
- sample_valid_o  out  1  one-cycle publish strobe.
- more_req_o  out  1  refill request to the host.
- underrun_o  out  1  sticky underrun flag.
- underrun_cnt_o  out  16  count of underruns.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low, with clock clk_i and reset rst_n_i.

Function
REQ-004 The FSM SHALL have exactly four states: PREBUF, FETCH, SETTLE, READY.
REQ-005 PREBUF -> FETCH SHALL occur when fifo_level_i >= START_LEVEL; fifo_rd_o SHALL stay low in PREBUF.
REQ-006 FETCH SHALL assert fifo_rd_o for one cycle when fifo_level_i != 0, latch fifo_data_i into the next byte slot, then go to SETTLE.
- If fifo_level_i == 0, FETCH SHALL stall with fifo_rd_o low.
REQ-007 SETTLE SHALL last exactly one cycle; it returns to FETCH until BYTES_PER_SAMPLE*CHANNELS bytes are held, then goes to READY.
- Consequence: at most one pop per two cycles.
REQ-008 Byte order SHALL be little-endian per channel, left channel first.
REQ-009 Each sample SHALL be MSB-aligned into 24 bits with LSBs zero-filled:
- 1 byte -> [23:16].
- 2 bytes -> [23:8].
- 3 bytes -> [23:0].
REQ-010 When CHANNELS==1, right_o SHALL equal left_o.
REQ-011 A sample_tick_i in READY SHALL, on the next edge:
- load left_o/right_o from the assembled frame;
- pulse sample_valid_o for one cycle;
- transition to FETCH.
REQ-012 An underrun is a sample_tick_i in FETCH or SETTLE. On an underrun the block SHALL:
- pulse sample_valid_o and apply the output rule of REQ-022;
- set underrun_o;
- increment underrun_cnt_o, saturating at 65535;
- continue assembling the partial frame.
REQ-013 A sample_tick_i in PREBUF SHALL NOT count as an underrun; it SHALL pulse sample_valid_o with left_o/right_o at zero.
REQ-014 A tick arriving in the same cycle READY is entered SHALL be honoured on the next edge; a tick in READY SHALL never be lost.
REQ-015 more_req_o SHALL be registered and equal (fifo_level_i < LOW_WATER), with one cycle of latency.
REQ-016 Worst-case latency from PREBUF exit to READY SHALL be 2*BYTES_PER_SAMPLE*CHANNELS cycles when the FIFO does not stall.

Reset
REQ-017 While rst_n_i is low at a clk_i edge, the following SHALL be 0: left_o, right_o, sample_valid_o, fifo_rd_o, underrun_o, underrun_cnt_o, and the byte index.
REQ-018 While rst_n_i is low at a clk_i edge, more_req_o SHALL be 1 and the state SHALL be PREBUF.
REQ-019 Reset asserted mid-frame SHALL discard partial bytes; no pop SHALL be issued in the reset cycle.
REQ-020 underrun_o SHALL clear only on reset.

Configuration
REQ-021 The macro UNPACK_UNDERRUN_MUTE_EN SHALL select underrun output behaviour.
REQ-022 Underrun output behaviour SHALL be:
- Defined: on an underrun, left_o and right_o SHALL be driven to 0.
- Undefined: on an underrun, left_o and right_o SHALL hold their previous values (repeat last sample).

Verification
REQ-023 Defaults, FIFO filled with 16 bytes 0x34,0x12,0x78,0x56,... plus ticks every 100 cycles -> first publish left_o=0x123400, right_o=0x567800; fifo_rd_o never high on consecutive cycles.
REQ-024 BYTES_PER_SAMPLE=3, CHANNELS=1, bytes 0x01,0x02,0x83 -> left_o=right_o=0x830201; sample_valid_o one cycle.
REQ-025 Level held at 0 after the first frame with ticks continuing:
- underrun_cnt_o increments per tick and saturates at 0xFFFF;
- outputs are 0 with the macro defined, or repeat the last sample without it.
REQ-026 Level swept 70 -> 63 -> 64 -> more_req_o goes 0, 1, 0, each one cycle after the level change.
REQ-027 rst_n_i pulsed low after 3 of 4 bytes -> next frame re-prebuffers (no pops until level >= 16) and the discarded bytes are not published.
